// File: rtl/ps2_key_decoder.sv
// Set-2 scan-code decoder: pops bytes from the PS/2 receiver FIFO and emits make/break events with ASCII.
// Latency: byte sampled in IDLE, event and level outputs registered at the end of ACK (1 clk later).
// Backpressure: one pop per 3 clk; ready is ignored until the FSM is back in IDLE.
// Ports: clk/clrn (sync active-low); ready/data/nextdata_n = receiver FIFO pop interface;
//        key_valid/key_make/key_code/key_ext/key_repeat/ascii = event; key_down/shift/ctrl/caps/press_count = levels.
module ps2_key_decoder (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic       key_valid,
    output logic       key_make,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_repeat,
    output logic [7:0] ascii,
    output logic       key_down,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {IDLE, ACK, SETTLE} state_t;

    state_t     state;
    logic [7:0] byte_r;
    logic       ext_p;
    logic       brk_p;
    logic [8:0] held;      // {ext, code} of the last newly pressed non-modifier key

    logic [7:0] letter;    // lowercase letter for byte_r, 0 if not a letter
    logic [7:0] other;     // digit / special character for byte_r, 0 if none
    logic [7:0] xlate;     // character for a non-extended make of byte_r
    logic [8:0] cur;
    logic       is_rep;

    always_comb begin
        letter = 8'h00;
        case (byte_r)
            8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
            8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
            8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
            default: letter = 8'h00;
        endcase
    end

    always_comb begin
        other = 8'h00;
        case (byte_r)
            8'h45: other = 8'h30; 8'h16: other = 8'h31; 8'h1E: other = 8'h32;
            8'h26: other = 8'h33; 8'h25: other = 8'h34; 8'h2E: other = 8'h35;
            8'h36: other = 8'h36; 8'h3D: other = 8'h37; 8'h3E: other = 8'h38;
            8'h46: other = 8'h39;
            8'h29: other = 8'h20; 8'h5A: other = 8'h0D; 8'h66: other = 8'h08;
            default: other = 8'h00;
        endcase
    end

    always_comb begin
        xlate = other;
        if (letter != 8'h00) begin
            // Uppercase is lowercase minus 0x20; ctrl folds either case to 0x01..0x1A.
            xlate = (shift ^ caps) ? (letter - 8'h20) : letter;
            if (ctrl)
                xlate = xlate & 8'h1F;
        end
    end

    assign cur    = {ext_p, byte_r};
    assign is_rep = key_down && (held == cur);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= IDLE;
            nextdata_n  <= 1'b1;
            byte_r      <= 8'h00;
            ext_p       <= 1'b0;
            brk_p       <= 1'b0;
            held        <= 9'h000;
            key_valid   <= 1'b0;
            key_make    <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_repeat  <= 1'b0;
            ascii       <= 8'h00;
            key_down    <= 1'b0;
            shift       <= 1'b0;
            ctrl        <= 1'b0;
            caps        <= 1'b0;
            press_count <= 8'h00;
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        byte_r     <= data;
                        nextdata_n <= 1'b0;
                        state      <= ACK;
                    end
                end
                ACK: begin
                    nextdata_n <= 1'b1;
                    state      <= SETTLE;
                    if (byte_r == 8'hE0) begin
                        ext_p <= 1'b1;
                    end else if (byte_r == 8'hF0) begin
                        brk_p <= 1'b1;
                    end else begin
                        key_valid  <= 1'b1;
                        key_make   <= ~brk_p;
                        key_code   <= byte_r;
                        key_ext    <= ext_p;
                        key_repeat <= 1'b0;
                        ascii      <= (!brk_p && !ext_p) ? xlate : 8'h00;
                        ext_p      <= 1'b0;
                        brk_p      <= 1'b0;
                        // Modifiers ignore the E0 prefix, so right Ctrl lands here too.
                        if (byte_r == 8'h12 || byte_r == 8'h59) begin
                            shift <= ~brk_p;
                        end else if (byte_r == 8'h14) begin
                            ctrl <= ~brk_p;
                        end else if (!brk_p) begin
                            if (is_rep) begin
                                key_repeat <= 1'b1;
                            end else begin
                                held        <= cur;
                                key_down    <= 1'b1;
                                press_count <= press_count + 8'd1;
                                if (byte_r == 8'h58)
                                    caps <= ~caps;
                            end
                        end else if (held == cur) begin
                            key_down <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    nextdata_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       nextdata_n, key_valid, key_make, key_ext, key_repeat;
    logic [7:0] key_code, ascii, press_count;
    logic       key_down, shift, ctrl, caps;

    ps2_key_decoder dut (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .nextdata_n(nextdata_n),
        .key_valid(key_valid), .key_make(key_make), .key_code(key_code), .key_ext(key_ext),
        .key_repeat(key_repeat), .ascii(ascii), .key_down(key_down), .shift(shift),
        .ctrl(ctrl), .caps(caps), .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       make;
        logic [7:0] code;
        logic       ext;
        logic       rep;
        logic [7:0] asc;
        logic       down, sh, ct, cp;
        logic [7:0] cnt;
    } ev_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nd_pulses = 0;
    int   kv_pulses = 0;
    logic prev_nd_low = 1'b0;
    logic prev_kv = 1'b0;
    logic pop_pend = 1'b0;
    logic [7:0] fifo[$];
    ev_t        exp_q[$];
    int         nd_cyc[$];

    // Reference model state (key-level view of the keyboard)
    logic       m_ext, m_brk, m_down, m_shift, m_ctrl, m_caps;
    logic [8:0] m_held;
    logic [7:0] m_cnt;

    logic [7:0] lcode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool  [12] = '{8'h1C, 8'h32, 8'h15, 8'h45, 8'h29, 8'h5A, 8'h12, 8'h59,
                               8'h14, 8'h58, 8'h75, 8'h66};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] m_ascii(input logic [7:0] c);
        string letters = "abcdefghijklmnopqrstuvwxyz";
        logic [7:0] ch;
        for (int i = 0; i < 26; i++) begin
            if (lcode[i] == c) begin
                ch = letters[i];
                if (m_shift ^ m_caps) ch = ch - 8'd32;
                if (m_ctrl) ch = ch % 8'd32;
                return ch;
            end
        end
        for (int i = 0; i < 10; i++)
            if (dcode[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_down = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
        m_held = 9'h0; m_cnt = 8'h0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            e.make = !m_brk; e.code = b; e.ext = m_ext; e.rep = 0;
            e.asc  = (e.make && !e.ext) ? m_ascii(b) : 8'h00;
            if (b == 8'h12 || b == 8'h59)      m_shift = e.make;
            else if (b == 8'h14)                m_ctrl = e.make;
            else if (e.make) begin
                if (m_down && m_held == {e.ext, b}) e.rep = 1;
                else begin
                    m_held = {e.ext, b};
                    m_down = 1;
                    m_cnt  = m_cnt + 1;
                    if (b == 8'h58) m_caps = !m_caps;
                end
            end else if (m_held == {e.ext, b}) m_down = 0;
            e.down = m_down; e.sh = m_shift; e.ct = m_ctrl; e.cp = m_caps; e.cnt = m_cnt;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic refresh();
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b, input bit modelled);
        fifo.push_back(b);
        if (modelled) model_byte(b);
        refresh();
    endtask

    task automatic step();
        ev_t e;
        @(posedge clk);
        #1;
        cyc++;
        // The receiver pops on the edge that closes the cycle where nextdata_n was low.
        if (pop_pend && fifo.size() != 0) void'(fifo.pop_front());
        pop_pend = (nextdata_n === 1'b0);
        refresh();
        chk("nd_width", prev_nd_low && (nextdata_n === 1'b0), 1'b0);
        chk("kv_width", prev_kv && (key_valid === 1'b1), 1'b0);
        if (nextdata_n === 1'b0) begin
            nd_pulses++;
            nd_cyc.push_back(cyc);
        end
        if (key_valid === 1'b1) begin
            kv_pulses++;
            chk("event_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("key_make", key_make, e.make);
                chk("key_code", key_code, e.code);
                chk("key_ext", key_ext, e.ext);
                chk("key_repeat", key_repeat, e.rep);
                chk("ascii", ascii, e.asc);
                chk("levels", {key_down, shift, ctrl, caps}, {e.down, e.sh, e.ct, e.cp});
                chk("press_count", press_count, e.cnt);
            end
        end
        prev_nd_low = (nextdata_n === 1'b0);
        prev_kv = (key_valid === 1'b1);
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || pop_pend) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", n < maxc, 1'b1);
        repeat (3) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {key_valid, key_make, key_code, key_ext, key_repeat, ascii,
                             key_down, shift, ctrl, caps, press_count}, 0);
        chk({tag, "_nd"}, nextdata_n, 1'b1);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        clrn = 1'b1;
        model_reset();
    endtask

    initial begin
        int n0, k0, n;
        logic [7:0] c;
        logic brk, ext;
        model_reset();
        refresh();

        // Basic make/break
        do_reset();
        push(8'h1C, 1); push(8'hF0, 1); push(8'h1C, 1);
        drain(100);

        // Shift and typematic repeat
        do_reset();
        foreach (lcode[i]) if (i == 0) begin end
        push(8'h12, 1); push(8'h1C, 1); push(8'h1C, 1); push(8'hF0, 1);
        push(8'h1C, 1); push(8'hF0, 1); push(8'h12, 1);
        drain(200);
        chk("t2_count", press_count, 8'd1);

        // Caps Lock toggling
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push(8'h58, 1); push(8'hF0, 1); push(8'h58, 1); push(8'h15, 1);
        end
        drain(200);
        chk("t3_count", press_count, 8'd4);
        chk("t3_caps", caps, 1'b0);

        // Extended key: 5 bytes, 2 events
        do_reset();
        n0 = nd_pulses; k0 = kv_pulses;
        push(8'hE0, 1); push(8'h75, 1); push(8'hE0, 1); push(8'hF0, 1); push(8'h75, 1);
        drain(200);
        chk("t4_nd_pulses", nd_pulses - n0, 5);
        chk("t4_kv_pulses", kv_pulses - k0, 2);

        // Throughput with ready held high; idle afterwards must stay quiet
        nd_cyc.delete();
        push(8'h1C, 1); push(8'hF0, 1); push(8'h1C, 1); push(8'h32, 1);
        drain(100);
        n0 = nd_pulses; k0 = kv_pulses;
        repeat (20) step();
        chk("idle_nd", nd_pulses - n0, 0);
        chk("idle_kv", kv_pulses - k0, 0);
        chk("tp_pulses", nd_cyc.size(), 4);
        if (nd_cyc.size() == 4)
            for (int i = 1; i < 4; i++) chk("tp_spacing", nd_cyc[i] - nd_cyc[i-1], 3);

        // 256 new presses wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) push((i % 2) ? 8'h32 : 8'h1C, 1);
        drain(2000);
        chk("wrap_count", press_count, 8'h00);

        // Reset during ACK of an F0 drops the prefix
        do_reset();
        push(8'hF0, 0);
        n = 0;
        while (nextdata_n !== 1'b0 && n < 20) begin step(); n++; end
        chk("ack_timeout", n < 20, 1'b1);
        clrn = 1'b0;
        step();
        chk_all_zero("midreset");
        clrn = 1'b1;
        model_reset();
        step();
        push(8'h1C, 1);
        drain(100);
        chk("midreset_make", key_make, 1'b1);
        chk("midreset_count", press_count, 8'd1);

        // Randomized key traffic against the reference model
        do_reset();
        for (int i = 0; i < 250; i++) begin
            c   = pool[$urandom_range(0, 11)];
            ext = ($urandom_range(0, 4) == 0);
            brk = ($urandom_range(0, 2) == 0);
            if (ext) push(8'hE0, 1);
            if (brk) push(8'hF0, 1);
            push(c, 1);
            repeat ($urandom_range(0, 4)) step();
        end
        drain(5000);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream consumer of the PS/2 receiver FIFO. Pops set-2 scan codes through the receiver's `ready`/`data`/`nextdata_n` interface and tracks the `E0` (extended) and `F0` (break) prefixes. Emits one decoded key event per make or break, with ASCII translation. Also maintains modifier state (Shift/Ctrl/Caps Lock), a held-key flag and a keypress counter for the display logic.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — system clock, shared with the receiver.
- `clrn` — input, 1 — reset; synchronous, active-low.
- `ready` — input, 1 — receiver FIFO non-empty.
- `data` — input, 8 — receiver FIFO head byte; valid while `ready=1`.
- `nextdata_n` — output, 1 — pop request to the receiver, active-low; registered.
- `key_valid` — output, 1 — one-cycle pulse; an event is present on the key_* outputs.
- `key_make` — output, 1 — 1 = press or repeat, 0 = release; valid with `key_valid`.
- `key_code` — output, 8 — scan code of the event, with prefixes stripped.
- `key_ext` — output, 1 — event was `E0`-prefixed.
- `key_repeat` — output, 1 — make event was a typematic repeat of the held key.
- `ascii` — output, 8 — translated character; `8'h00` if unmapped or on release.
- `key_down` — output, 1 — a non-modifier key is currently held.
- `shift` — output, 1 — modifier level.
- `ctrl` — output, 1 — modifier level.
- `caps` — output, 1 — modifier level.
- `press_count` — output, 8 — count of new (non-repeat, non-modifier) presses; wraps at 8'hFF→8'h00.

## Operation
- **Reset** (`clrn=0` at a clk edge): state IDLE; `nextdata_n=1`; every other output 0; prefix flags and held-code register cleared.
- **FSM states**
  - IDLE: if `ready=1`, latch `data` into `byte_r`, set `nextdata_n<=0`, go to ACK.
  - ACK: `nextdata_n` is low for exactly this cycle, so the receiver pops on its closing edge. Decode `byte_r` and register the results; set `nextdata_n<=1`; go to SETTLE.
  - SETTLE: one cycle so the receiver's `ready`/`data` reflect the pop; go to IDLE.
- **Decode of `byte_r` in ACK**
  - `E0`: set `ext_p`; no event.
  - `F0`: set `brk_p`; no event.
  - Any other byte is a final code. It produces one event with `key_ext=ext_p`, `key_make=~brk_p`, then clears both `ext_p` and `brk_p`.
- **Modifiers** (`ext_p` ignored; `14` also covers right Ctrl `E0 14`)
  - `12`/`59` set/clear `shift`; `14` sets/clears `ctrl`.
  - Modifiers still emit events but do not affect `key_down` or `press_count`.
- **Caps Lock** `58`: toggles `caps` on a non-repeat make only. It is a normal key for `key_down` and `press_count`.
- **Make of a non-modifier key**
  - If `key_down=1` and {ext, code} equals the held register: `key_repeat=1`, no count.
  - Otherwise: store {ext, code} in the held register, set `key_down`, increment `press_count`, `key_repeat=0`.
- **Break**: if {ext, code} matches the held register, clear `key_down`. A break of a non-held key emits an event only.
- **ASCII mapping** (non-extended makes only; everything else → 00; letters in lowercase unless `shift^caps`, then uppercase)
  - Letters: a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A.
  - Digits 0–9: 45 16 1E 26 25 2E 36 3D 3E 46; shift ignored.
  - Special keys: space 29→20, enter 5A→0D, backspace 66→08.
  - `ctrl=1` with a letter: ascii = letter & 8'h1F.

## Timing
- **Byte latency**: byte sampled at edge E0 (IDLE, `ready=1`). Decoded outputs update at E1 (end of ACK). `key_valid=1` for exactly the cycle E1–E2; `key_*` and `ascii` hold until the next event.
- **Throughput**: one FIFO byte per 3 clk. `ready` is never re-sampled in the cycle after a pop.
- **Pulse widths**: `nextdata_n` is never low for more than one cycle and is never low while in IDLE or SETTLE. `key_valid` is never high for two consecutive cycles.
- **Empty FIFO**: with `ready=0` the block remains in IDLE indefinitely with outputs held.
- **Level outputs**: modifier, `key_down` and `press_count` changes become visible in the same cycle as `key_valid`.
- **Reset mid-operation**: reset in ACK drives `nextdata_n=1` from the next cycle and drops partial prefixes.

## Test plan
- Reset, then push `1C`, `F0 1C` → two events: make code 1C ascii 61 with `press_count=1` and `key_down=1`, then break with `key_down=0` and ascii 00.
- Push `12 1C 1C F0 1C F0 12` → `shift` 1 then 0; second `1C` has ascii 41 and `key_repeat=1`; `press_count` stays 1.
- Push `58 F0 58 15`, then `58 F0 58 15` → caps toggles 1→0; ascii 51 then 71; `press_count` ends at 4.
- Push `E0 75`, `E0 F0 75` → `key_ext=1`, `key_code=75`, ascii 00; exactly two `key_valid` pulses; `nextdata_n` low once per byte (5 pulses).
- Hold `ready=1` with 4 queued bytes → `nextdata_n` low exactly every third cycle; 256 new presses wrap `press_count` to 00.
- Assert `clrn=0` during ACK after an `F0` → all outputs 0, `nextdata_n=1`; a subsequent `1C` decodes as a make.
